// File: rtl/muldiv_issue_ctrl.sv
// Execute-stage requester for the RV32M mul/div unit: latches an M-op,
// starts the unit, stalls the pipeline until the result is back, and hands
// the result to writeback. A one-entry cache returns a repeated identical
// op without re-issuing it.
//
// Writeback handshake: wb_valid_o is high for the whole RESP state and
// wb_rd_o/wb_data_o do not change while it is high; the result is
// transferred in a cycle where wb_valid_o & wb_ready_i & ~flush_i.
module muldiv_issue_ctrl #(
    parameter bit REUSE_EN = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        valid_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] rs1_val_i,
    input  logic [31:0] rs2_val_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        md_start_o,
    output logic [31:0] md_operand_a_o,
    output logic [31:0] md_operand_b_o,
    output logic [2:0]  md_op_o,
    input  logic        md_busy_i,
    input  logic        md_done_i,
    input  logic [31:0] md_result_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    input  logic        wb_ready_i,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_accept;
    logic        w_hit;
    logic        w_capture;
    logic        w_start;
    logic        w_match;

    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [4:0]  r_rd;
    logic [31:0] r_wb_data;

    logic        r_c_valid;
    logic [2:0]  r_c_op;
    logic [31:0] r_c_a;
    logic [31:0] r_c_b;
    logic [31:0] r_c_res;

    // The destination register is deliberately not part of the match.
    assign w_match = REUSE_EN && r_c_valid && (op_i == r_c_op) &&
                     (rs1_val_i == r_c_a) && (rs2_val_i == r_c_b);

    // Next-state and control strobes; flush wins over every other event.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_hit       = 1'b0;
        w_capture   = 1'b0;
        w_start     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (valid_i && !flush_i) begin
                    w_accept = 1'b1;
                    if (w_match) begin
                        w_hit       = 1'b1;
                        w_state_nxt = S_RESP;
                    end else begin
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                w_start = ~md_busy_i;
                if (flush_i) begin
                    // Once started the unit cannot be aborted, so drain it.
                    w_state_nxt = w_start ? S_DRAIN : S_IDLE;
                end else if (w_start) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (md_done_i) begin
                    if (flush_i) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_capture   = 1'b1;
                        w_state_nxt = S_RESP;
                    end
                end else if (flush_i) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_RESP: begin
                if (flush_i || wb_ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (md_done_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand and destination latch, loaded only when an op is accepted.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_op <= 3'd0;
            r_a  <= 32'd0;
            r_b  <= 32'd0;
            r_rd <= 5'd0;
        end else if (w_accept) begin
            r_op <= op_i;
            r_a  <= rs1_val_i;
            r_b  <= rs2_val_i;
            r_rd <= rd_addr_i;
        end
    end

    // Writeback data: cached result on a hit, unit result on completion.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wb_data <= 32'd0;
        end else if (w_hit) begin
            r_wb_data <= r_c_res;
        end else if (w_capture) begin
            r_wb_data <= md_result_i;
        end
    end

    // Reuse cache: every completion is recorded, even a flushed or drained
    // one, because the result is still correct for the latched operands.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_c_valid <= 1'b0;
            r_c_op    <= 3'd0;
            r_c_a     <= 32'd0;
            r_c_b     <= 32'd0;
            r_c_res   <= 32'd0;
        end else if (md_done_i) begin
            r_c_valid <= 1'b1;
            r_c_op    <= r_op;
            r_c_a     <= r_a;
            r_c_b     <= r_b;
            r_c_res   <= md_result_i;
        end
    end

    assign md_start_o     = w_start;
    assign md_operand_a_o = r_a;
    assign md_operand_b_o = r_b;
    assign md_op_o        = r_op;
    assign wb_valid_o     = (r_state == S_RESP);
    assign wb_rd_o        = r_rd;
    assign wb_data_o      = r_wb_data;
    assign dbg_state_o    = r_state;

    // The upstream op retires in the same cycle as the writeback handshake.
    assign stall_o = valid_i & ~((r_state == S_RESP) & wb_ready_i & ~flush_i);

endmodule

// File: doc/muldiv_issue_ctrl.md
# muldiv_issue_ctrl

Execute-stage requester for the RV32M mul/div unit. It takes a decoded M-extension instruction from the pipeline, latches its operands, pulses `start_i` of `muldiv_unit`, stalls the pipeline until `done_o`, and presents the result to writeback with a valid/ready handshake. It also handles pipeline flushes while the unit is running, and can return a repeated identical operation from a one-entry result cache without re-issuing it.

## Interface
- `REUSE_EN`, default 1: enables the one-entry last-result reuse cache. When 0, every operation is issued to the unit.
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_n_i` in 1: asynchronous, active-low reset.
- `valid_i` in 1: pipeline presents an M-op. The op and operands are stable while `stall_o` is high.
- `op_i` in 3: mul/div op code, passed unchanged to `muldiv_op_i` (MUL=0, DIV=1, REM=3, …).
- `rs1_val_i` in 32: operand A.
- `rs2_val_i` in 32: operand B.
- `rd_addr_i` in 5: destination register.
- `flush_i` in 1: kills the in-flight instruction.
- `stall_o` out 1: holds the upstream pipeline.
- `md_start_o` out 1: to unit `start_i`; single-cycle pulse.
- `md_operand_a_o` out 32: to unit `operand_a_i`, from latched registers.
- `md_operand_b_o` out 32: to unit `operand_b_i`, from latched registers.
- `md_op_o` out 3: to unit `muldiv_op_i`, from latched registers.
- `md_busy_i` in 1: from unit `busy_o`.
- `md_done_i` in 1: from unit `done_o`; 1-cycle pulse; `md_result_i` is valid in that cycle only.
- `md_result_i` in 32: from unit `result_o`.
- `wb_valid_o` out 1: result available for writeback.
- `wb_rd_o` out 5: destination register for writeback.
- `wb_data_o` out 32: result data for writeback.
- `wb_ready_i` in 1: writeback accepts the result.

## Operation
**States:** IDLE, ISSUE, WAIT, RESP, DRAIN.

**IDLE**
- The op is accepted when `valid_i=1` and `flush_i=0`. On acceptance, latch op, a, b and rd.
- Reuse hit: `REUSE_EN=1`, cache valid, and op/a/b equal the cached op/a/b.
  - Load the cached result into `wb_data_o` and go to RESP.
- Otherwise go to ISSUE.

**ISSUE**
- `md_start_o = ~md_busy_i`.
- When `md_start_o=1`, go to WAIT. While `md_busy_i=1`, stay in ISSUE with `md_start_o=0`.
- `flush_i=1` with start asserted goes to DRAIN. `flush_i=1` without start goes to IDLE.

**WAIT**
- On `md_done_i`, capture `md_result_i` into `wb_data_o` and go to RESP.
- `flush_i=1` without `md_done_i` goes to DRAIN. `flush_i=1` with `md_done_i` goes to IDLE and the result is discarded.

**RESP**
- `wb_valid_o=1`; `wb_rd_o` and `wb_data_o` are held stable.
- `wb_ready_i=1` goes to IDLE.
- `flush_i=1` goes to IDLE without the writeback handshake; flush has priority over `wb_ready_i`.

**DRAIN**
- The unit cannot be aborted, so wait for `md_done_i`, discard the result and go to IDLE.
- `stall_o` follows the rule below.

**stall_o**
- `stall_o = valid_i & ~(state==RESP & wb_ready_i & ~flush_i)`.
- The upstream instruction retires in the same cycle the writeback handshake completes.

**Reuse cache**
- Fields: valid, op, a, b, result.
- Written on every `md_done_i`, including discarded or drained results, since the result is still correct for its operands.
- Cleared only by reset.
- `rd` is not part of the match.
- Arithmetic is done by the unit only; this block does no data transformation.

## Timing
- **Reset values:** state=IDLE, `stall_o` follows `valid_i` (combinational), `md_start_o=0`, `md_operand_a_o=0`, `md_operand_b_o=0`, `md_op_o=0`, `wb_valid_o=0`, `wb_rd_o=0`, `wb_data_o=0`, cache valid=0.
- **Reset mid-operation:** returns to IDLE immediately. The unit is reset by the same `rst_n_i`.
- **Miss latency:**
  - Accept edge T; `md_start_o` high in cycle T+1.
  - `md_done_i` arrives after L unit cycles; `wb_valid_o` rises the cycle after `md_done_i`.
  - Total from accept to `wb_valid_o` = L + 2 cycles.
- **Hit latency:** `wb_valid_o` is high in the cycle after acceptance.
- `md_start_o` is never high for two consecutive cycles and never high outside ISSUE.
- `md_done_i` outside WAIT/DRAIN is ignored except for the cache update.
- Back-to-back: after the RESP→IDLE handshake, the next op is accepted in the IDLE cycle. Minimum spacing between writebacks is 2 cycles.

## Test plan
- **MUL miss:** a=6, b=7, op=0 → exactly one `md_start_o` pulse. After `md_done_i`, `wb_valid_o=1`, `wb_data_o=42`, rd echoed. `stall_o` is low in the handshake cycle.
- **DIV then identical repeat:** 20/4 twice (REUSE_EN=1) → both return 5. The second issues no `md_start_o` and reaches `wb_valid_o` 1 cycle after acceptance. With REUSE_EN=0 the second issues normally.
- **Writeback backpressure:** REM 21%4 with `wb_ready_i` held low 5 cycles → `wb_valid_o=1` and `wb_data_o=1` stable throughout. Retires on the first `wb_ready_i=1`.
- **Flush in WAIT:** DIV 100/3, `flush_i` 2 cycles after start → DRAIN. No `wb_valid_o`. A new MUL 3*5 presented during DRAIN is not started until after the old `md_done_i`, then returns 15.
- **Flush in RESP:** flush with `wb_valid_o=1` and `wb_ready_i=1` in the same cycle → no handshake, IDLE next cycle.
- **Async reset in WAIT:** assert `rst_n_i` mid-cycle → all outputs zero immediately. The cache is invalid, so a repeat of the prior op re-issues to the unit.
